led_display_rx: RTL and testbench
=================================

Name: led_display_rx

Overview:
- Display-side receiver for the serial dot/control interface driven by the LED write FSM: data_in, chip_enable, rs, control_rstn and blank.
- Models the four cascaded 5x8 display chips: a 160-bit dot shift register with a dot latch, plus control word 0 and control word 1.
- Used as the bench responder for the write FSM, and as an on-chip loopback/readback monitor of what the display holds.

Parameters:
- DOT_BITS, 160, total dot shift register length (4 chars x 40 bits); must be a multiple of CHAR_BITS.
- CHAR_BITS, 40, bits per character (5 columns x 8 rows).

Ports:
- led_clk  in  1  interface clock; all inputs are sampled on the rising edge (the writer drives on the falling edge).
- rstn  in  1  asynchronous active-low reset.
- data_in  in  1  serial data, MSB first.
- chip_enable  in  1  0 = frame in progress, 1 = idle; the 0->1 edge commits the frame.
- rs  in  1  1 = control frame, 0 = dot frame; sampled on the first bit only.
- control_rstn  in  1  synchronous active-low clear of both control words.
- blank  in  1  1 = display blanked.
- rd_char  in  2  character select for readback.
- rd_dots  out  40  dot latch content of the selected character, combinational mux.
- ctrl_word0  out  7  control word 0 bits D6..D0.
- ctrl_word1  out  7  control word 1 bits D6..D0.
- display_on  out  1  = !blank & ctrl_word0[6].
- dot_update  out  1  one-cycle pulse when the dot latch loads.
- ctrl_update  out  1  one-cycle pulse when a control word loads.
- frame_error  out  1  one-cycle pulse when a frame is rejected or malformed.
- busy  out  1  high while in SHIFT or COMMIT.

Behaviour:
- Reset: clears the shift registers, dot latch, both control words, bit count and state. All outputs are 0; state goes to IDLE.
- States: IDLE, SHIFT, COMMIT.
- IDLE -> SHIFT on the first posedge with chip_enable=0.
  - On that edge, capture frame_rs <= rs and shift in the first bit. Set bit_cnt to 1.
- SHIFT: while chip_enable=0, shift one bit per posedge and increment bit_cnt (8-bit, saturates at 255).
  - rs changes mid-frame are ignored.
  - chip_enable=1 moves to COMMIT; no bit is shifted on that edge.
- Dot frame shifting: dot_sr <= {dot_sr[DOT_BITS-2:0], data_in}.
  - dot_sr persists across frames (it is not cleared at frame start), so a 40-bit write pushes the older characters along, as the real cascade does.
- Control frame shifting: ctl_sr[7:0] <= {ctl_sr[6:0], data_in}.
- COMMIT, dot frame:
  - dot_latch <= dot_sr and dot_update=1.
  - frame_error=1 if bit_cnt is not a multiple of CHAR_BITS or exceeds DOT_BITS; the latch still loads.
- COMMIT, control frame:
  - Requires bit_cnt==8 exactly. Otherwise discard and pulse frame_error.
  - ctl_sr[7]=0: ctrl_word0 <= ctl_sr[6:0].
  - ctl_sr[7]=1: require ctl_sr[6:2]==0, else discard with frame_error; otherwise ctrl_word1 <= ctl_sr[6:0].
  - ctrl_update=1 on any load.
- COMMIT -> IDLE unconditionally. If chip_enable=0 already on the COMMIT cycle, that bit is not captured; the next frame starts from IDLE.
- Readback mapping: after a 160-bit frame, the first character sent sits in dot_latch[159:120].
  - rd_char=0 -> [159:120], 1 -> [119:80], 2 -> [79:40], 3 -> [39:0].
- control_rstn=0 on a posedge: clears ctrl_word0 and ctrl_word1. It overrides a same-cycle control commit and does not affect the dot path.
- rstn asserted mid-frame aborts the frame: no commit and no pulse.

Optional Feature:
- LED_RX_STATS_EN defined: adds outputs dot_frame_cnt[15:0], ctrl_frame_cnt[15:0] and err_cnt[7:0].
  - Each increments on dot_update, ctrl_update and frame_error respectively, and saturates at all-ones.
  - All three clear on rstn only.
- Undefined: these ports and registers do not exist.

Test Plan:
- 160-bit dot frame:
  - Stimulus: frame with char0=40'hFF00000001 followed by chars 1-3 = 0, then CE rise.
  - Response: rd_char=0 returns 40'hFF00000001, rd_char=1..3 return 0; dot_update pulses once; frame_error=0.
- Scrolling:
  - Stimulus: after the above, send a 40-bit frame of 40'h123456789A.
  - Response: rd_char=3 = 40'h123456789A; rd_char=2 = 0; rd_char=0 = 0; the old char0 has shifted out; no error.
- Control word 0:
  - Stimulus: rs=1, bits 8'h4F.
  - Response: ctrl_word0=7'h4F, display_on=1 with blank=0 and 0 with blank=1; ctrl_update pulses.
- Control word 1:
  - 8'h81 -> ctrl_word1=7'h01.
  - 8'hA1 -> discarded, frame_error pulses, ctrl_word1 stays 7'h01.
- Malformed control frame and control clear:
  - Stimulus: 7-bit control frame, then control_rstn=0 for one cycle.
  - Response: the 7-bit frame gives frame_error with word0 unchanged; after control_rstn, ctrl_word0=ctrl_word1=0 and display_on=0.
- Reset mid-frame:
  - Stimulus: rstn low after 20 bits of a dot frame.
  - Response: busy=0, dot_latch=0, no dot_update; the next 160-bit frame loads correctly.

Source files
------------

// File: rtl/led_display_rx.sv
// led_display_rx: display-side receiver for the serial dot/control interface.
// Models four cascaded 5x8 display chips: a dot shift register with a dot
// latch, plus control words 0 and 1, with a combinational readback mux.
// Optional build macro LED_RX_STATS_EN adds saturating frame/error counters.
module led_display_rx #(
  parameter int DOT_BITS  = 160,
  parameter int CHAR_BITS = 40
) (
  input  logic                 led_clk,
  input  logic                 rstn,
  input  logic                 data_in,
  input  logic                 chip_enable,
  input  logic                 rs,
  input  logic                 control_rstn,
  input  logic                 blank,
  input  logic [1:0]           rd_char,
  output logic [CHAR_BITS-1:0] rd_dots,
  output logic [6:0]           ctrl_word0,
  output logic [6:0]           ctrl_word1,
  output logic                 display_on,
  output logic                 dot_update,
  output logic                 ctrl_update,
  output logic                 frame_error,
  output logic                 busy
`ifdef LED_RX_STATS_EN
  ,
  output logic [15:0]          dot_frame_cnt,
  output logic [15:0]          ctrl_frame_cnt,
  output logic [7:0]           err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state;
  logic                frame_rs;
  logic [7:0]          bit_cnt;
  logic [DOT_BITS-1:0] dot_sr;
  logic [DOT_BITS-1:0] dot_latch;
  logic [7:0]          ctl_sr;
  logic                dot_len_bad;

  // A dot frame is malformed unless it carries whole characters and fits the cascade
  assign dot_len_bad = ((int'(bit_cnt) % CHAR_BITS) != 0) || (int'(bit_cnt) > DOT_BITS);

  assign display_on = !blank && ctrl_word0[6];
  assign busy       = (state == SHIFT) || (state == COMMIT);

  // Readback: character 0 is the first one sent, so it sits at the top of the latch
  always_comb begin
    rd_dots = dot_latch[DOT_BITS-1 - int'(rd_char)*CHAR_BITS -: CHAR_BITS];
  end

  // Frame FSM: shift bits while chip_enable is low, commit on its rising edge
  always_ff @(posedge led_clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      frame_rs    <= 1'b0;
      bit_cnt     <= 8'd0;
      dot_sr      <= '0;
      dot_latch   <= '0;
      ctl_sr      <= 8'd0;
      ctrl_word0  <= 7'd0;
      ctrl_word1  <= 7'd0;
      dot_update  <= 1'b0;
      ctrl_update <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      dot_update  <= 1'b0;
      ctrl_update <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!chip_enable) begin
            state    <= SHIFT;
            frame_rs <= rs;
            bit_cnt  <= 8'd1;
            if (rs) ctl_sr <= {ctl_sr[6:0], data_in};
            else    dot_sr <= {dot_sr[DOT_BITS-2:0], data_in};
          end
        end
        SHIFT: begin
          if (chip_enable) begin
            state <= COMMIT;
          end else begin
            if (bit_cnt != 8'hFF) bit_cnt <= bit_cnt + 8'd1;
            if (frame_rs) ctl_sr <= {ctl_sr[6:0], data_in};
            else          dot_sr <= {dot_sr[DOT_BITS-2:0], data_in};
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (!frame_rs) begin
            dot_latch   <= dot_sr;
            dot_update  <= 1'b1;
            frame_error <= dot_len_bad;
          end else if (bit_cnt != 8'd8) begin
            frame_error <= 1'b1;
          end else if (!ctl_sr[7]) begin
            if (control_rstn) begin
              ctrl_word0  <= ctl_sr[6:0];
              ctrl_update <= 1'b1;
            end
          end else if (ctl_sr[6:2] != 5'd0) begin
            frame_error <= 1'b1;
          end else if (control_rstn) begin
            ctrl_word1  <= ctl_sr[6:0];
            ctrl_update <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (!control_rstn) begin
        ctrl_word0 <= 7'd0;
        ctrl_word1 <= 7'd0;
      end
    end
  end

`ifdef LED_RX_STATS_EN
  // Saturating event counters, cleared only by the async reset
  always_ff @(posedge led_clk or negedge rstn) begin
    if (!rstn) begin
      dot_frame_cnt  <= 16'd0;
      ctrl_frame_cnt <= 16'd0;
      err_cnt        <= 8'd0;
    end else begin
      if (dot_update && (dot_frame_cnt != 16'hFFFF))   dot_frame_cnt  <= dot_frame_cnt + 16'd1;
      if (ctrl_update && (ctrl_frame_cnt != 16'hFFFF)) ctrl_frame_cnt <= ctrl_frame_cnt + 16'd1;
      if (frame_error && (err_cnt != 8'hFF))           err_cnt        <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_led_display_rx.sv
// tb_led_display_rx: randomized self-checking bench for led_display_rx.
// The reference model keeps the history of dot bits in a queue and decodes
// control bytes directly from their rules.
module tb_led_display_rx;

  localparam int DOT_BITS  = 160;
  localparam int CHAR_BITS = 40;

  logic led_clk = 1'b0;
  logic rstn = 1'b0;
  logic data_in = 1'b0;
  logic chip_enable = 1'b1;
  logic rs = 1'b0;
  logic control_rstn = 1'b1;
  logic blank = 1'b0;
  logic [1:0] rd_char = 2'd0;
  logic [CHAR_BITS-1:0] rd_dots;
  logic [6:0] ctrl_word0, ctrl_word1;
  logic display_on, dot_update, ctrl_update, frame_error, busy;
`ifdef LED_RX_STATS_EN
  logic [15:0] dot_frame_cnt, ctrl_frame_cnt;
  logic [7:0]  err_cnt;
`endif

  led_display_rx #(.DOT_BITS(DOT_BITS), .CHAR_BITS(CHAR_BITS)) dut (
    .led_clk(led_clk), .rstn(rstn), .data_in(data_in), .chip_enable(chip_enable),
    .rs(rs), .control_rstn(control_rstn), .blank(blank), .rd_char(rd_char),
    .rd_dots(rd_dots), .ctrl_word0(ctrl_word0), .ctrl_word1(ctrl_word1),
    .display_on(display_on), .dot_update(dot_update), .ctrl_update(ctrl_update),
    .frame_error(frame_error), .busy(busy)
`ifdef LED_RX_STATS_EN
    , .dot_frame_cnt(dot_frame_cnt), .ctrl_frame_cnt(ctrl_frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 led_clk = ~led_clk;

  int checks = 0;
  int failures = 0;
  int dot_pulses = 0, ctrl_pulses = 0, err_pulses = 0;
  int exp_dot = 0, exp_ctrl = 0, exp_err = 0;
  bit dot_hist[$];
  logic [6:0] m_word0 = 7'd0;
  logic [6:0] m_word1 = 7'd0;
  logic [255:0] bits;

  // Count output pulses away from the sampling edge
  always @(negedge led_clk) begin
    if (dot_update)  dot_pulses++;
    if (ctrl_update) ctrl_pulses++;
    if (frame_error) err_pulses++;
  end

  // Hang guard
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Character c of the latch: the last DOT_BITS dot bits sent, first-sent at the top
  function automatic logic [CHAR_BITS-1:0] modelChar(input int c);
    logic [CHAR_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < CHAR_BITS; k++) begin
      int p, idx;
      p   = DOT_BITS - (c + 1) * CHAR_BITS + k;
      idx = dot_hist.size() - 1 - p;
      if (idx >= 0) r[k] = dot_hist[idx];
    end
    return r;
  endfunction

  task automatic modelFrame(input logic is_ctrl, input logic [255:0] b, input int n);
    if (!is_ctrl) begin
      for (int i = n - 1; i >= 0; i--) dot_hist.push_back(b[i]);
      while (dot_hist.size() > DOT_BITS) void'(dot_hist.pop_front());
      exp_dot++;
      if ((n % CHAR_BITS) != 0 || n > DOT_BITS) exp_err++;
    end else if (n != 8) begin
      exp_err++;
    end else if (b[7] == 1'b0) begin
      m_word0 = b[6:0];
      exp_ctrl++;
    end else if (b[6:2] != 5'd0) begin
      exp_err++;
    end else begin
      m_word1 = b[6:0];
      exp_ctrl++;
    end
  endtask

  // Drive one frame on the falling edge, MSB first, then raise chip_enable
  task automatic applyStimulus(input logic is_ctrl, input logic [255:0] b, input int n);
    @(negedge led_clk);
    rs = is_ctrl;
    chip_enable = 1'b0;
    data_in = b[n-1];
    for (int i = n - 2; i >= 0; i--) begin
      @(negedge led_clk);
      data_in = b[i];
      rs = 1'($urandom_range(0, 1));
    end
    @(negedge led_clk);
    chip_enable = 1'b1;
    data_in = 1'b0;
    repeat (3) @(negedge led_clk);
    modelFrame(is_ctrl, b, n);
  endtask

  task automatic checkState(input string tag);
    for (int c = 0; c < 4; c++) begin
      rd_char = 2'(c);
      #1;
      checkOutput($sformatf("%s_rd%0d", tag, c), 64'(rd_dots), 64'(modelChar(c)));
    end
    checkOutput({tag, "_word0"}, 64'(ctrl_word0), 64'(m_word0));
    checkOutput({tag, "_word1"}, 64'(ctrl_word1), 64'(m_word1));
    checkOutput({tag, "_disp"}, 64'(display_on), 64'(!blank && m_word0[6]));
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_dotpulses"}, 64'(dot_pulses), 64'(exp_dot));
    checkOutput({tag, "_ctlpulses"}, 64'(ctrl_pulses), 64'(exp_ctrl));
    checkOutput({tag, "_errpulses"}, 64'(err_pulses), 64'(exp_err));
  endtask

  task automatic modelReset();
    dot_hist.delete();
    m_word0 = 7'd0;
    m_word1 = 7'd0;
  endtask

  function automatic logic [255:0] randBits();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int n;
    logic is_ctrl;

    // Reset state
    repeat (2) @(negedge led_clk);
    modelReset();
    checkState("reset");
    rstn = 1'b1;
    @(negedge led_clk);

    // 160-bit dot frame
    bits = '0;
    bits[159:0] = {40'hFF00000001, 120'd0};
    applyStimulus(1'b0, bits, 160);
    checkState("dot160");
    rd_char = 2'd0; #1;
    checkOutput("dot160_char0_const", 64'(rd_dots), 64'h00FF00000001);
    rd_char = 2'd1; #1;
    checkOutput("dot160_char1_const", 64'(rd_dots), 64'd0);

    // Scrolling 40-bit frame
    bits = '0;
    bits[39:0] = 40'h123456789A;
    applyStimulus(1'b0, bits, 40);
    checkState("scroll");
    rd_char = 2'd3; #1;
    checkOutput("scroll_char3_const", 64'(rd_dots), 64'h00123456789A);
    rd_char = 2'd0; #1;
    checkOutput("scroll_char0_const", 64'(rd_dots), 64'd0);

    // Control word 0 and display_on vs blank
    bits = '0;
    bits[7:0] = 8'h4F;
    applyStimulus(1'b1, bits, 8);
    checkState("cw0");
    checkOutput("cw0_const", 64'(ctrl_word0), 64'h4F);
    checkOutput("cw0_disp_on", 64'(display_on), 64'd1);
    blank = 1'b1; #1;
    checkOutput("cw0_disp_blank", 64'(display_on), 64'd0);
    blank = 1'b0;

    // Control word 1: legal then illegal
    bits[7:0] = 8'h81;
    applyStimulus(1'b1, bits, 8);
    checkState("cw1_ok");
    checkOutput("cw1_const", 64'(ctrl_word1), 64'h01);
    bits[7:0] = 8'hA1;
    applyStimulus(1'b1, bits, 8);
    checkState("cw1_bad");

    // Short control frame, then control clear
    bits[7:0] = 8'h2A;
    applyStimulus(1'b1, bits, 7);
    checkState("ctl7");
    @(negedge led_clk);
    control_rstn = 1'b0;
    @(negedge led_clk);
    control_rstn = 1'b1;
    m_word0 = 7'd0;
    m_word1 = 7'd0;
    checkState("ctlclr");

    // Reset mid-frame
    bits = randBits();
    @(negedge led_clk);
    rs = 1'b0;
    chip_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data_in = bits[i];
      @(negedge led_clk);
    end
    checkOutput("midrst_busy_before", 64'(busy), 64'd1);
    rstn = 1'b0;
    chip_enable = 1'b1;
    #1;
    modelReset();
    checkState("midrst");
    @(negedge led_clk);
    rstn = 1'b1;
    bits = randBits();
    applyStimulus(1'b0, bits, 160);
    checkState("after_rst");

    // Randomized frames
    for (int t = 0; t < 40; t++) begin
      is_ctrl = ($urandom_range(0, 2) == 0);
      bits = randBits();
      if (is_ctrl) begin
        case ($urandom_range(0, 4))
          0: n = 7;
          1: n = 9;
          default: n = 8;
        endcase
        if ($urandom_range(0, 1) == 1) bits[6:2] = 5'd0;
      end else begin
        case ($urandom_range(0, 5))
          0: n = 40;
          1: n = 80;
          2: n = 120;
          3: n = 160;
          4: n = 200;
          default: n = $urandom_range(1, 170);
        endcase
      end
      blank = 1'($urandom_range(0, 1));
      applyStimulus(is_ctrl, bits, n);
      if ($urandom_range(0, 7) == 0) begin
        control_rstn = 1'b0;
        @(negedge led_clk);
        control_rstn = 1'b1;
        m_word0 = 7'd0;
        m_word1 = 7'd0;
      end
      checkState($sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
